// File: rtl/my_node_info_pkg.sv
// Shared definitions for the my_node_info bookkeeping block: packet types,
// Q2.14 constants, datapath width and the sequencer state encoding.
package my_node_info_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CHE  = 3'b001;
    localparam logic [2:0] PKT_CHI  = 3'b010;
    localparam logic [2:0] PKT_NONE = 3'b111;

    localparam int              Q_FRAC = 14;
    localparam logic [DATA_W-1:0] Q_ONE  = 16'h4000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DIV_E,
        ST_DIV_H,
        ST_UPDATE
    } mni_state_t;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/mni_seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle.
// Quotient is exact when dividend[2W-1:W] < divisor.
module mni_seq_divider
    import my_node_info_pkg::*;
#(
    parameter int DIV_BITS = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [2*DATA_W-1:0]   dividend,
    input  logic [DATA_W-1:0]     divisor,
    output logic [DATA_W-1:0]     quotient,
    output logic                  busy,
    output logic                  last
);

    localparam int CW = $clog2(DIV_BITS + 1);

    logic [DATA_W-1:0] rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] dsr;
    logic [CW-1:0]     cnt;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;
    logic              take;

    assign shifted = {rem, quo[DATA_W-1]};
    assign diff    = shifted - {1'b0, dsr};
    assign take    = shifted >= {1'b0, dsr};

    always_ff @(posedge clk) begin
        if (nrst) begin
            rem <= '0;
            quo <= '0;
            dsr <= '0;
            cnt <= '0;
        end else if (start) begin
            rem <= dividend[2*DATA_W-1:DATA_W];
            quo <= dividend[DATA_W-1:0];
            dsr <= divisor;
            cnt <= CW'(DIV_BITS);
        end else if (busy) begin
            rem <= take ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], take};
            cnt <= cnt - CW'(1);
        end
    end

    assign busy     = (cnt != '0);
    assign last     = (cnt == CW'(1));
    assign quotient = quo;

endmodule

// File: rtl/my_node_info.sv
// Per-node hop/Q-value/role bookkeeping for the clustering engine.
// Optional macro MNI_LOW_E_STICKY_EN: low_E latches until reset and forces role=0.
module my_node_info
    import my_node_info_pkg::*;
#(
    parameter logic [15:0] NODE_ID  = 16'h0001,
    parameter int          DIV_BITS = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        en_MNI,
    input  logic [2:0]  fPktType,
    input  logic [15:0] e_max,
    input  logic [15:0] e_min,
    input  logic [15:0] energy,
    input  logic [15:0] ch_ID,
    input  logic [15:0] hops,
    input  logic [15:0] timeslot,
    input  logic [15:0] e_threshold,
    output logic [15:0] myNodeID,
    output logic [15:0] hopsFromSink,
    output logic [15:0] myQValue,
    output logic        role,
    output logic        low_E
);

    // state     | meaning
    // ST_IDLE   | waiting for a valid packet capture
    // ST_DIV_E  | normalised energy division running
    // ST_DIV_H  | load and run Q = normE / hops division
    // ST_UPDATE | write Q to myQValue

    mni_state_t state, state_nxt;

    logic [15:0] hops_q, q_q, ts_q;
    logic        role_q, low_q, role_nxt, low_nxt;
    logic        e_low_q, e_high_q, h_loaded;
    logic        capture, valid_type;
    logic [15:0] new_hops, norm_e, h_div;

    logic                div_start, div_busy, div_last;
    logic [2*DATA_W-1:0] div_dividend;
    logic [DATA_W-1:0]   div_divisor, div_quotient;

    assign valid_type = (fPktType == PKT_HB) || (fPktType == PKT_CHE) || (fPktType == PKT_CHI);
    assign capture    = en_MNI && (state == ST_IDLE) && valid_type;
    assign new_hops   = sat_inc(hops);
    assign h_div      = (hops_q == '0) ? 16'h0001 : hops_q;

    always_comb begin
        norm_e = div_quotient;
        if (e_low_q)
            norm_e = '0;
        else if (e_high_q || (div_quotient > Q_ONE))
            norm_e = Q_ONE;
    end

    always_comb begin
        state_nxt    = state;
        div_start    = 1'b0;
        div_dividend = '0;
        div_divisor  = '0;
        case (state)
            ST_IDLE: begin
                if (capture && (fPktType == PKT_HB)) begin
                    state_nxt    = ST_DIV_E;
                    div_start    = 1'b1;
                    div_dividend = {2'b00, (energy - e_min), {Q_FRAC{1'b0}}};
                    div_divisor  = e_max - e_min;
                end
            end
            ST_DIV_E: begin
                if (div_last)
                    state_nxt = ST_DIV_H;
            end
            ST_DIV_H: begin
                if (!h_loaded) begin
                    div_start    = 1'b1;
                    div_dividend = {{DATA_W{1'b0}}, norm_e};
                    div_divisor  = h_div;
                end else if (div_last) begin
                    state_nxt = ST_UPDATE;
                end
            end
            ST_UPDATE: state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        low_nxt  = low_q;
        role_nxt = role_q;
        if (capture) begin
`ifdef MNI_LOW_E_STICKY_EN
            low_nxt = low_q | (energy < e_threshold);
`else
            low_nxt = (energy < e_threshold);
`endif
            if (fPktType == PKT_CHE)
                role_nxt = (ch_ID == NODE_ID);
            else if ((fPktType == PKT_CHI) && (ch_ID != NODE_ID))
                role_nxt = 1'b0;
        end
`ifdef MNI_LOW_E_STICKY_EN
        if (low_nxt)
            role_nxt = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (nrst) begin
            state    <= ST_IDLE;
            hops_q   <= 16'hFFFF;
            q_q      <= '0;
            role_q   <= 1'b0;
            low_q    <= 1'b0;
            ts_q     <= '0;
            e_low_q  <= 1'b0;
            e_high_q <= 1'b0;
            h_loaded <= 1'b0;
        end else begin
            state    <= state_nxt;
            role_q   <= role_nxt;
            low_q    <= low_nxt;
            h_loaded <= (state == ST_DIV_H);
            if (capture) begin
                e_low_q  <= (energy <= e_min);
                e_high_q <= (energy >= e_max) || (e_max <= e_min);
                if ((fPktType == PKT_HB) && (new_hops < hops_q))
                    hops_q <= new_hops;
                if ((fPktType == PKT_CHI) && (ch_ID != NODE_ID))
                    ts_q <= timeslot;
            end
            if (state == ST_UPDATE)
                q_q <= div_quotient;
        end
    end

    mni_seq_divider #(.DIV_BITS(DIV_BITS)) u_div (
        .clk      (clk),
        .nrst     (nrst),
        .start    (div_start),
        .dividend (div_dividend),
        .divisor  (div_divisor),
        .quotient (div_quotient),
        .busy     (div_busy),
        .last     (div_last)
    );

    assign myNodeID     = NODE_ID;
    assign hopsFromSink = hops_q;
    assign myQValue     = q_q;
    assign role         = role_q;
    assign low_E        = low_q;

endmodule

// File: tb/tb_my_node_info.sv
// Directed plus randomized bench for my_node_info against an arithmetic reference model.
module tb_my_node_info;

    localparam logic [15:0] NODE_ID = 16'h0001;

    logic        clk = 1'b0;
    logic        nrst, en_MNI;
    logic [2:0]  fPktType;
    logic [15:0] e_max, e_min, energy, ch_ID, hops, timeslot, e_threshold;
    logic [15:0] myNodeID, hopsFromSink, myQValue;
    logic        role, low_E;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    int m_hops, m_q, m_role, m_low, m_ts;

    always #5 clk = ~clk;

    my_node_info dut (
        .clk(clk), .nrst(nrst), .en_MNI(en_MNI), .fPktType(fPktType),
        .e_max(e_max), .e_min(e_min), .energy(energy), .ch_ID(ch_ID),
        .hops(hops), .timeslot(timeslot), .e_threshold(e_threshold),
        .myNodeID(myNodeID), .hopsFromSink(hopsFromSink), .myQValue(myQValue),
        .role(role), .low_E(low_E)
    );

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_hops = 16'hFFFF; m_q = 0; m_role = 0; m_low = 0; m_ts = 0;
    endtask

    // Q from the model's point of view: normalised energy over hop distance.
    function automatic int model_q(input int emax, input int emin, input int e);
        int ne, h;
        if (e <= emin)                     ne = 0;
        else if (e >= emax || emax <= emin) ne = 16384;
        else begin
            ne = ((e - emin) * 16384) / (emax - emin);
            if (ne > 16384) ne = 16384;
        end
        h = (m_hops == 0) ? 1 : m_hops;
        return ne / h;
    endfunction

    task automatic model_capture(input int t, input int e, input int cid,
                                 input int hp, input int ts, input int th);
        int nh, lowc;
        if (!(t == 0 || t == 1 || t == 2)) return;
        lowc = (e < th) ? 1 : 0;
`ifdef MNI_LOW_E_STICKY_EN
        m_low = m_low | lowc;
`else
        m_low = lowc;
`endif
        if (t == 0) begin
            nh = (hp >= 65535) ? 65535 : hp + 1;
            if (nh < m_hops) m_hops = nh;
        end else if (t == 1) begin
            m_role = (cid == NODE_ID) ? 1 : 0;
        end else if (cid != NODE_ID) begin
            m_ts = ts; m_role = 0;
        end
`ifdef MNI_LOW_E_STICKY_EN
        if (m_low != 0) m_role = 0;
`endif
    endtask

    task automatic drive(input int t, input int emax, input int emin, input int e,
                         input int cid, input int hp, input int ts, input int th);
        fPktType = 3'(t); e_max = 16'(emax); e_min = 16'(emin); energy = 16'(e);
        ch_ID = 16'(cid); hops = 16'(hp); timeslot = 16'(ts); e_threshold = 16'(th);
    endtask

    task automatic send(input string tag, input int t, input int emax, input int emin,
                        input int e, input int cid, input int hp, input int ts, input int th);
        int q_new;
        @(negedge clk);
        drive(t, emax, emin, e, cid, hp, ts, th);
        en_MNI = 1'b1;
        @(posedge clk); #1;
        en_MNI = 1'b0;
        model_capture(t, e, cid, hp, ts, th);
        check({tag, "_hops"}, hopsFromSink, m_hops);
        check({tag, "_low"},  low_E, m_low);
        check({tag, "_role"}, role, m_role);
        if (t == 0) begin
            q_new = model_q(emax, emin, e);
            repeat (33) @(posedge clk);
            #1 check({tag, "_qhold"}, myQValue, m_q);
            @(posedge clk); #1;
            check({tag, "_qlat"}, myQValue, q_new);
            m_q = q_new;
        end
    endtask

    initial begin
        int t, emax, emin, e, cid, hp, sel;
        nrst = 1'b1; en_MNI = 1'b0;
        drive(7, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (5) @(posedge clk);
        #1;
        check("rst_hops", hopsFromSink, 16'hFFFF);
        check("rst_q", myQValue, 0);
        check("rst_role", role, 0);
        check("rst_low", low_E, 0);
        check("node_id", myNodeID, 16'h0001);
        @(negedge clk) nrst = 1'b0;

        // Saturation: hops=FFFF cannot improve on an unknown distance.
        send("hb_sat", 0, 16'h8000, 16'h4000, 16'h8000, 0, 16'hFFFF, 0, 16'h3333);
        check("hb_sat_hops_const", hopsFromSink, 16'hFFFF);

        send("hb1", 0, 16'h8000, 16'h4000, 16'h8000, 0, 1, 0, 16'h3333);
        check("hb1_q_const", myQValue, 16'h2000);
        send("hb2", 0, 16'h8000, 16'h4000, 16'h8000, 0, 5, 0, 16'h3333);
        check("hb2_hops_const", hopsFromSink, 2);
        send("hb3", 0, 16'h8000, 16'h4000, 16'h6000, 0, 0, 0, 16'h3333);
        check("hb3_q_const", myQValue, 16'h2000);
        send("hb_low", 0, 16'h8000, 16'h4000, 16'h3000, 0, 3, 0, 16'h3333);
        check("hb_low_const", low_E, 1);
        check("hb_low_q_const", myQValue, 0);
        send("hb_rec", 0, 16'h8000, 16'h4000, 16'h7000, 0, 0, 0, 16'h3333);
        send("che", 1, 0, 0, 16'h7000, 16'h0001, 0, 0, 16'h3333);
        send("chi", 2, 0, 0, 16'h7000, 16'h0007, 0, 3, 16'h3333);
        send("che_other", 1, 0, 0, 16'h7000, 16'h0009, 0, 0, 16'h3333);
        send("che_me", 1, 0, 0, 16'h7000, 16'h0001, 0, 0, 16'h3333);
        send("chi_me", 2, 0, 0, 16'h7000, 16'h0001, 0, 4, 16'h3333);
        send("none", 7, 0, 0, 16'h0000, 16'h0009, 0, 0, 16'h3333);
        send("inval", 5, 0, 0, 16'h0000, 16'h0009, 0, 0, 16'h3333);

        // en_MNI held high while busy must be ignored.
        @(negedge clk);
        drive(0, 16'hC000, 16'h4000, 16'h8000, 0, 0, 0, 16'h3333);
        en_MNI = 1'b1;
        @(posedge clk); #1;
        model_capture(0, 16'h8000, 0, 0, 0, 16'h3333);
        sel = model_q(16'hC000, 16'h4000, 16'h8000);
        drive(1, 0, 0, 0, 16'h0009, 0, 0, 16'hFFFF);
        repeat (10) @(posedge clk);
        #1 en_MNI = 1'b0;
        repeat (24) @(posedge clk);
        #1;
        check("busy_q", myQValue, sel);
        check("busy_role", role, m_role);
        check("busy_low", low_E, m_low);
        m_q = sel;

        // Reset in the middle of the second division aborts the update.
        @(negedge clk);
        drive(0, 16'h8000, 16'h4000, 16'h8000, 0, 0, 0, 16'h3333);
        en_MNI = 1'b1;
        @(posedge clk); #1;
        en_MNI = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk) nrst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        check("abort_hops", hopsFromSink, 16'hFFFF);
        check("abort_q", myQValue, 0);
        check("abort_low", low_E, 0);
        @(negedge clk) nrst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("abort_noupd", myQValue, 0);

        for (int i = 0; i < 25; i++) begin
            sel  = $urandom_range(0, 5);
            t    = (sel < 3) ? sel : ((sel == 3) ? 7 : 3 + $urandom_range(0, 3));
            emin = $urandom_range(0, 16'h6000);
            emax = $urandom_range(0, 16'hFFFF);
            e    = $urandom_range(0, 16'hFFFF);
            cid  = ($urandom_range(0, 1) == 1) ? 1 : $urandom_range(0, 16'hFFFF);
            hp   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : $urandom_range(0, 20);
            send($sformatf("rnd%0d", i), t, emax, emin, e, cid, hp,
                 $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/my_node_info.md
Name: my_node_info

Overview:
- Per-node bookkeeping block for the EER-RL clustering/routing engine.
- Consumes fields decoded from a received packet, qualified by en_MNI and fPktType.
- Maintains hop distance to sink, node Q-value, cluster role and low-energy flag.
- Feeds the routing/RL update logic.
- All energy quantities are unsigned Q2.14: 0x4000 = 1.0, 0x8000 = 2.0, 0x3333 ≈ 0.8.

Parameters:
- NODE_ID, 16'h0001, this node's identifier, driven on myNodeID.
- DIV_BITS, 16, iterations per sequential division.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  synchronous reset, active-high (1 = reset).
- en_MNI  in  1  packet-field valid / enable.
- fPktType  in  3  packet type: 000 HB (heartbeat), 001 CHE (cluster-head election), 010 CHI (CH invite/timeslot), 111 none; others ignored.
- e_max  in  16  network max energy, Q2.14.
- e_min  in  16  network min energy, Q2.14.
- energy  in  16  this node's residual energy, Q2.14.
- ch_ID  in  16  cluster-head ID carried by CHE/CHI.
- hops  in  16  sender's hop count (HB).
- timeslot  in  16  TDMA slot (CHI).
- e_threshold  in  16  low-energy threshold, Q2.14.
- myNodeID  out  16  constant NODE_ID.
- hopsFromSink  out  16  registered hop distance.
- myQValue  out  16  registered Q-value, Q2.14.
- role  out  1  0 = member, 1 = cluster head.
- low_E  out  1  energy below threshold.

Behaviour:
- Reset (nrst=1 at a clk edge) sets:
  - hopsFromSink = 16'hFFFF.
  - myQValue = 0.
  - role = 0.
  - low_E = 0.
  - Stored timeslot = 0.
  - FSM = IDLE.
- Reset mid-computation aborts the computation; no partial result is written.
- FSM states: IDLE, DIV_E, DIV_H, UPDATE.
- Capture: in IDLE, at an edge with en_MNI=1 and fPktType in {000,001,010}, latch all inputs. en_MNI is ignored outside IDLE.
- At capture, for any valid type: low_E <= (energy < e_threshold), unsigned compare.
- HB (000):
  - newHops = hops + 1, saturating at 0xFFFF.
  - If newHops < hopsFromSink, then hopsFromSink <= newHops; otherwise unchanged.
  - Go to DIV_E.
- DIV_E: normE = ((energy - e_min) << 14) / (e_max - e_min), restoring divide, DIV_BITS cycles.
  - energy <= e_min gives normE = 0.
  - energy >= e_max, or e_max <= e_min, gives normE = 0x4000.
  - Result is clamped to 0x4000.
- DIV_H: Q = normE / H, integer divisor, DIV_BITS cycles. H = updated hopsFromSink, with 0 treated as 1.
- UPDATE: myQValue <= Q; return to IDLE.
- Latency: myQValue changes on the edge 2*DIV_BITS+2 cycles after the capture edge (34 with defaults). It holds its value in between.
- CHE (001):
  - role <= (ch_ID == NODE_ID), one cycle after capture.
  - Stay in IDLE; no Q recompute.
- CHI (010): if ch_ID != NODE_ID, store timeslot and set role <= 0; stay in IDLE.
- Invalid or 111 types while en_MNI=1: no state change.
- myNodeID is combinational constant NODE_ID.

Optional Feature:
- Macro MNI_LOW_E_STICKY_EN.
- Defined: once low_E is set it stays 1 until reset, and role is forced to 0 whenever low_E=1, so a low-energy node never acts as CH.
- Undefined: low_E is re-evaluated at every capture and may clear; role follows CHE/CHI only.

Decomposition:
- Shared package holds:
  - Packet-type localparams PKT_HB, PKT_CHE, PKT_CHI, PKT_NONE.
  - Q2.14 constants Q_ONE=16'h4000 and Q_FRAC=14.
  - The FSM state enum.
  - Widths.
- One natural sub-module: mni_seq_divider, a DIV_BITS-iteration unsigned restoring divider with start/done handshake, used twice sequentially.

Test Plan:
- Reset: nrst=1 for 5 cycles → hopsFromSink=FFFF, myQValue=0, role=0, low_E=0, myNodeID=0001.
- HB capture: hops=1, e_max=8000, e_min=4000, energy=8000, e_threshold=3333, en_MNI pulse → hopsFromSink=2, low_E=0, and 34 cycles later myQValue=2000.
- Second HB with hops=5 → hopsFromSink stays 2. Then HB with hops=0, energy=6000 → hopsFromSink=1, myQValue=2000 (normE=0.5).
- Low energy: HB with energy=3000, e_threshold=3333 → low_E=1, myQValue=0.
- Role: CHE with ch_ID=0001 → role=1. CHI with ch_ID=0007, timeslot=3 → role=0.
- Busy/abort: en_MNI held high during DIV_E is ignored. nrst mid-DIV_H → outputs return to reset values and no update occurs.
